// File: rtl/wr_ddr_packer_if.sv
// Pixel-side beat input, DDR-side word output and FIFO status of the write packer.
interface wr_ddr_packer_if #(
    parameter int unsigned IN_WIDTH    = 64,
    parameter int unsigned OUT_WIDTH   = 256,
    parameter int unsigned DEPTH_WIDTH = 4
);
    logic                   in_valid;
    logic [IN_WIDTH-1:0]    in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   out_valid;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_last;
    logic                   out_ready;
    logic                   burst_req;
    logic [DEPTH_WIDTH:0]   level;
    logic                   almost_full;
    logic                   full;

    // Packer side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last,
               burst_req, level, almost_full, full
    );

    // Video source / DDR master side
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last,
               burst_req, level, almost_full, full
    );
endinterface

// File: rtl/wr_ddr_packer.sv
// Packs four 64-bit pixel beats into one 256-bit DDR word and queues words
// in a show-ahead FIFO; requests a burst when a full burst or tail is ready.
module wr_ddr_packer #(
    parameter int unsigned IN_WIDTH        = 64,
    parameter int unsigned OUT_WIDTH       = 256,
    parameter int unsigned DEPTH_WIDTH     = 4,
    parameter int unsigned BURST_LEN       = 8,
    parameter int unsigned ALMOST_FULL_NUM = 12
) (
    input  logic              clk,
    input  logic              rst,
    wr_ddr_packer_if.slave    bus
);
    localparam int unsigned LANES  = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned DEPTH  = 1 << DEPTH_WIDTH;
    localparam int unsigned LVL_W  = DEPTH_WIDTH + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  BURST_LVL = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  AF_LVL    = LVL_W'(ALMOST_FULL_NUM);

    typedef struct packed {
        logic                 last;
        logic [OUT_WIDTH-1:0] data;
    } entry_t;

    entry_t               mem [DEPTH];
    entry_t               head;
    logic [LANE_W-1:0]    lane_q;
    logic [OUT_WIDTH-1:0] pack_q;
    logic [OUT_WIDTH-1:0] word_c;
    logic [LVL_W-1:0]     wr_ptr_q;
    logic [LVL_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     tail_q;
    logic [LVL_W-1:0]     wr_ptr_nxt;
    logic [LVL_W-1:0]     rd_ptr_nxt;
    logic [LVL_W-1:0]     level_nxt;
    logic [LVL_W-1:0]     tail_nxt;
    logic                 ready_q;
    logic                 valid_q;
    logic                 full_q;
    logic                 af_q;
    logic                 burst_q;
    logic                 accept;
    logic                 push;
    logic                 pop;

    assign head = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];

    // Handshakes, word assembly and next FIFO occupancy
    always_comb begin
        accept     = bus.in_valid && ready_q;
        push       = accept && ((lane_q == LAST_LANE) || bus.in_last);
        pop        = valid_q && bus.out_ready;
        word_c     = pack_q;
        word_c[32'(lane_q) * IN_WIDTH +: IN_WIDTH] = bus.in_data;
        wr_ptr_nxt = wr_ptr_q + LVL_W'(push);
        rd_ptr_nxt = rd_ptr_q + LVL_W'(pop);
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        tail_nxt   = tail_q + LVL_W'(push && bus.in_last) - LVL_W'(pop && head.last);
    end

    // Lane counter, pointers and registered status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q   <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tail_q   <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            burst_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (push) begin
                    lane_q <= '0;
                    pack_q <= '0;
                end else begin
                    lane_q <= lane_q + LANE_W'(1);
                    pack_q <= word_c;
                end
            end
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            level_q  <= level_nxt;
            tail_q   <= tail_nxt;
            ready_q  <= (level_nxt != FULL_LVL);
            valid_q  <= (level_nxt != '0);
            full_q   <= (level_nxt == FULL_LVL);
            af_q     <= (level_nxt >= AF_LVL);
            burst_q  <= (level_nxt >= BURST_LVL) || (tail_nxt != '0);
        end
    end

    // Word storage; upper lanes of a flushed word are already zero in pack_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= '{last: bus.in_last, data: word_c};
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = valid_q ? head.data : '0;
    assign bus.out_last    = valid_q && head.last;
    assign bus.burst_req   = burst_q;
    assign bus.level       = level_q;
    assign bus.almost_full = af_q;
    assign bus.full        = full_q;
endmodule

// File: tb/tb_wr_ddr_packer.sv
// Bench for wr_ddr_packer: directed steps plus random traffic against a
// queue-based model of beats and stored words.
module tb_wr_ddr_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wr_ddr_packer_if #(.IN_WIDTH(64), .OUT_WIDTH(256), .DEPTH_WIDTH(4)) bus ();

    wr_ddr_packer #(
        .IN_WIDTH(64), .OUT_WIDTH(256), .DEPTH_WIDTH(4),
        .BURST_LEN(8), .ALMOST_FULL_NUM(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: stored words {last, data} in FIFO order and beats of the open word
    logic [256:0] q [$];
    logic [63:0]  beats [$];
    logic         last_acc;

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tail_words();
        int n = 0;
        foreach (q[i]) if (q[i][256]) n++;
        return n;
    endfunction

    task automatic check_state();
        int lvl = q.size();
        chk("level",       257'(bus.level),       257'(lvl));
        chk("out_valid",   257'(bus.out_valid),   257'(lvl != 0));
        chk("in_ready",    257'(bus.in_ready),    257'(lvl != 16));
        chk("full",        257'(bus.full),        257'(lvl == 16));
        chk("almost_full", 257'(bus.almost_full), 257'(lvl >= 12));
        chk("burst_req",   257'(bus.burst_req),   257'((lvl >= 8) || (tail_words() != 0)));
        if (lvl != 0)
            chk("head_word", {bus.out_last, bus.out_data}, q[0]);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare
    task automatic step(input logic v, input logic [63:0] d, input logic l, input logic r);
        logic pop;
        logic [255:0] w;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        last_acc = v && (q.size() != 16);
        pop      = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (last_acc) begin
            beats.push_back(d);
            if (beats.size() == 4 || l) begin
                w = '0;
                foreach (beats[i]) w[i*64 +: 64] = beats[i];
                q.push_back({l, w});
                beats.delete();
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_state();
    endtask

    // Hold a beat until it is accepted, bounded
    task automatic send(input logic [63:0] d, input logic l, input logic r);
        int n = 0;
        do begin
            step(1'b1, d, l, r);
            n++;
        end while (!last_acc && n < 100);
        if (!last_acc) chk("send_timeout", 257'(0), 257'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("drain_empty", 257'(bus.level), 257'(0));
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready",    257'(bus.in_ready),    257'(1));
        chk("rst_out_valid",   257'(bus.out_valid),   257'(0));
        chk("rst_out_data",    {bus.out_last, bus.out_data}, 257'(0));
        chk("rst_burst_req",   257'(bus.burst_req),   257'(0));
        chk("rst_level",       257'(bus.level),       257'(0));
        chk("rst_almost_full", 257'(bus.almost_full), 257'(0));
        chk("rst_full",        257'(bus.full),        257'(0));
    endtask

    initial begin
        logic [63:0] k;
        logic [63:0] cur;
        logic        have;
        logic        cur_l;
        logic        v;
        logic        r;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Four beats make one word, lane 0 in the low bits
        send(64'h11, 1'b0, 1'b0);
        send(64'h22, 1'b0, 1'b0);
        send(64'h33, 1'b0, 1'b0);
        send(64'h44, 1'b0, 1'b0);
        chk("pack4_word", {bus.out_last, bus.out_data},
            {1'b0, 64'h44, 64'h33, 64'h22, 64'h11});
        chk("pack4_level", 257'(bus.level), 257'(1));
        step(1'b0, '0, 1'b0, 1'b1);

        // Flushed tail word with zeroed upper lanes
        send(64'hA, 1'b0, 1'b0);
        send(64'hB, 1'b1, 1'b0);
        chk("tail_word", {bus.out_last, bus.out_data},
            {1'b1, 64'h0, 64'h0, 64'hB, 64'hA});
        chk("tail_burst_req", 257'(bus.burst_req), 257'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("tail_pop_burst_req", 257'(bus.burst_req), 257'(0));
        chk("tail_pop_level", 257'(bus.level), 257'(0));

        // Fill to full with a held beat behind it, then one single pop
        k = 64'h1000;
        for (int i = 0; i < 70; i++) begin
            step(1'b1, k, 1'b0, 1'b0);
            if (last_acc) k++;
        end
        chk("fill_full", 257'(bus.full), 257'(1));
        step(1'b1, k, 1'b0, 1'b1);
        chk("one_pop_level", 257'(bus.level), 257'(15));
        chk("one_pop_in_ready", 257'(bus.in_ready), 257'(1));
        drain();

        // Level 5, then a continuous stream with a pop on every word push
        for (int i = 0; i < 20; i++) send({$urandom, $urandom}, 1'b0, 1'b0);
        for (int i = 0; i < 160; i++) send({$urandom, $urandom}, 1'b0, beats.size() == 3);
        chk("stream_level", 257'(bus.level), 257'(5));
        drain();

        // Random traffic with held beats, first backpressured, then draining
        have  = 1'b0;
        cur   = '0;
        cur_l = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!have) begin
                v     = ($urandom_range(0, 3) != 0);
                cur   = {$urandom, $urandom};
                cur_l = ($urandom_range(0, 7) == 0);
                have  = v;
            end
            r = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(have, cur, cur_l, r);
            if (last_acc) have = 1'b0;
        end
        if (have) send(cur, 1'b1, 1'b0);
        send(64'hF00D, 1'b1, 1'b0);
        drain();

        // Reset with three stored words and two packed lanes
        for (int i = 0; i < 14; i++) send(64'hDEAD_0000 + 64'(i), 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        q.delete();
        beats.delete();
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        send(64'h1, 1'b0, 1'b0);
        send(64'h2, 1'b0, 1'b0);
        send(64'h3, 1'b0, 1'b0);
        send(64'h4, 1'b0, 1'b0);
        chk("post_rst_word", {bus.out_last, bus.out_data},
            {1'b0, 64'h4, 64'h3, 64'h2, 64'h1});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
